// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the fetch PC, drives a single-outstanding req/valid memory port
// and presents one instruction (or a NOP bubble) per cycle to decode, with freeze and redirect.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'hBFC00000,
  parameter logic [31:0] NOP_INSTR = 32'h00000000
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] Alt_PC,
  input  logic        Request_Alt_PC,
  input  logic        WANT_FREEZE,
  input  logic [31:0] IMem_Data,
  input  logic        IMem_Valid,
  output logic [31:0] IMem_Addr,
  output logic        IMem_Req,
  output logic [31:0] Instr1_OUT,
  output logic [31:0] Instr_PC_OUT,
  output logic [31:0] Instr_PC_Plus4_OUT,
  output logic        Fetch_Misaligned,
  output logic [31:0] Bubble_Count
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] fetch_pc;
  logic [31:0] hold_data;
  logic [31:0] pending_pc;
  logic        redirect_pending;
  logic        squash;

  logic [31:0] alt_aligned;
  logic [31:0] pc_plus4;
  logic [31:0] follow_pc;
  logic [31:0] next_pc;
  logic        present;
  logic [31:0] present_data;

  assign alt_aligned = {Alt_PC[31:2], 2'b00};
  assign pc_plus4    = fetch_pc + 32'd4;
  // A redirect seen at this edge beats one parked during a freeze, which beats sequential flow.
  assign follow_pc   = redirect_pending ? pending_pc : pc_plus4;
  assign next_pc     = Request_Alt_PC ? alt_aligned : follow_pc;

  always_comb begin
    present      = 1'b0;
    present_data = hold_data;
    if (!WANT_FREEZE) begin
      if (state == S_WAIT && IMem_Valid && !squash) begin
        present      = 1'b1;
        present_data = IMem_Data;
      end else if (state == S_HOLD) begin
        present = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state              <= S_REQ;
      fetch_pc           <= RESET_PC;
      hold_data          <= 32'd0;
      pending_pc         <= 32'd0;
      redirect_pending   <= 1'b0;
      squash             <= 1'b0;
      IMem_Addr          <= 32'd0;
      IMem_Req           <= 1'b0;
      Instr1_OUT         <= NOP_INSTR;
      Instr_PC_OUT       <= 32'd0;
      Instr_PC_Plus4_OUT <= 32'd0;
      Fetch_Misaligned   <= 1'b0;
      Bubble_Count       <= 32'd0;
    end else begin
      if (Request_Alt_PC && (Alt_PC[1:0] != 2'b00)) begin
        Fetch_Misaligned <= 1'b1;
      end

      // fetch_pc always names the word being presented here, so the PC outputs come from it.
      if (present) begin
        Instr1_OUT         <= present_data;
        Instr_PC_OUT       <= fetch_pc;
        Instr_PC_Plus4_OUT <= pc_plus4;
      end else if (!WANT_FREEZE) begin
        Instr1_OUT   <= NOP_INSTR;
        Bubble_Count <= Bubble_Count + 32'd1;
      end

      case (state)
        S_REQ: begin
          IMem_Addr <= Request_Alt_PC ? alt_aligned : fetch_pc;
          fetch_pc  <= Request_Alt_PC ? alt_aligned : fetch_pc;
          IMem_Req  <= 1'b1;
          state     <= S_WAIT;
        end

        S_WAIT: begin
          if (IMem_Valid) begin
            if (squash) begin
              squash   <= 1'b0;
              IMem_Req <= 1'b0;
              state    <= S_REQ;
              if (Request_Alt_PC) begin
                fetch_pc <= alt_aligned;
              end
            end else if (!WANT_FREEZE) begin
              fetch_pc  <= next_pc;
              IMem_Addr <= next_pc;
            end else begin
              // fetch_pc keeps the buffered word's PC; redirects park in pending_pc meanwhile.
              hold_data <= IMem_Data;
              IMem_Req  <= 1'b0;
              state     <= S_HOLD;
              if (Request_Alt_PC) begin
                redirect_pending <= 1'b1;
                pending_pc       <= alt_aligned;
              end
            end
          end else if (Request_Alt_PC) begin
            squash   <= 1'b1;
            fetch_pc <= alt_aligned;
          end
        end

        S_HOLD: begin
          if (!WANT_FREEZE) begin
            fetch_pc         <= next_pc;
            redirect_pending <= 1'b0;
            state            <= S_REQ;
          end else if (Request_Alt_PC) begin
            redirect_pending <= 1'b1;
            pending_pc       <= alt_aligned;
          end
        end

        default: begin
          state    <= S_REQ;
          IMem_Req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: a behavioural memory plus a program-order reference model (queue of
// captured PCs, next-PC register, redirect/stale bookkeeping), a directed table and random stimulus.
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'hBFC00000;
  localparam logic [31:0] NOP      = 32'h00000000;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic [31:0] Alt_PC = 32'd0;
  logic        Request_Alt_PC = 1'b0;
  logic        WANT_FREEZE = 1'b0;
  logic [31:0] IMem_Data = 32'd0;
  logic        IMem_Valid = 1'b0;
  logic [31:0] IMem_Addr;
  logic        IMem_Req;
  logic [31:0] Instr1_OUT;
  logic [31:0] Instr_PC_OUT;
  logic [31:0] Instr_PC_Plus4_OUT;
  logic        Fetch_Misaligned;
  logic [31:0] Bubble_Count;

  fetch_stage #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP)) dut (
    .CLK(CLK), .RESET(RESET), .Alt_PC(Alt_PC), .Request_Alt_PC(Request_Alt_PC),
    .WANT_FREEZE(WANT_FREEZE), .IMem_Data(IMem_Data), .IMem_Valid(IMem_Valid),
    .IMem_Addr(IMem_Addr), .IMem_Req(IMem_Req), .Instr1_OUT(Instr1_OUT),
    .Instr_PC_OUT(Instr_PC_OUT), .Instr_PC_Plus4_OUT(Instr_PC_Plus4_OUT),
    .Fetch_Misaligned(Fetch_Misaligned), .Bubble_Count(Bubble_Count)
  );

  always #5 CLK = ~CLK;

  int tests = 0;
  int fails = 0;

  // Reference model state
  logic [31:0] m_cur;
  logic [31:0] m_q[$];
  logic [31:0] m_bc;
  logic        m_mis;
  logic [31:0] e_instr, e_pc, e_pc4;
  int          edge_n = 0;
  int          last_redir;
  // Memory model state
  int          lat_mode;
  logic        mem_busy;
  int          mem_left;
  logic [31:0] mem_addr;
  int          mem_issue;
  int          resp_issue;
  logic        m_live;

  typedef struct {
    logic        fz;
    logic        r;
    logic [31:0] alt;
    logic        nop;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        req;
    logic [31:0] bc;
    logic        mis;
  } vec_t;
  vec_t tbl[15];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5A5A5A5;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_cur = RESET_PC;
    m_q.delete();
    m_bc = 0;
    m_mis = 1'b0;
    e_instr = NOP;
    e_pc = 0;
    e_pc4 = 0;
    last_redir = -1;
    resp_issue = -1;
    mem_busy = 1'b0;
    m_live = 1'b0;
  endtask

  task automatic do_reset();
    RESET = 1'b0;
    Request_Alt_PC = 1'b0;
    WANT_FREEZE = 1'b0;
    IMem_Valid = 1'b0;
    model_reset();
    @(negedge CLK);
    @(negedge CLK);
    RESET = 1'b1;
  endtask

  // One clock edge: sample inputs, advance the model, compare, then run the memory.
  task automatic step();
    logic fz, r, v, req_b;
    logic [31:0] alt, addr_b;
    fz = WANT_FREEZE; r = Request_Alt_PC; alt = Alt_PC;
    v = IMem_Valid && m_live; req_b = IMem_Req; addr_b = IMem_Addr;
    @(posedge CLK);
    #1;
    edge_n++;
    // A response is stale when a redirect happened after its issue and before its arrival.
    if (v && !(last_redir > resp_issue)) begin
      m_q.push_back(m_cur);
      m_cur = m_cur + 32'd4;
    end
    if (r) begin
      m_cur = {alt[31:2], 2'b00};
      last_redir = edge_n;
      if (alt[1:0] != 2'b00) m_mis = 1'b1;
    end
    if (!fz) begin
      if (m_q.size() > 0) begin
        e_pc = m_q.pop_front();
        e_instr = mem_word(e_pc);
        e_pc4 = e_pc + 32'd4;
      end else begin
        e_instr = NOP;
        m_bc = m_bc + 32'd1;
      end
    end
    chk($sformatf("instr@%0d", edge_n), Instr1_OUT, e_instr);
    chk($sformatf("pc@%0d", edge_n), Instr_PC_OUT, e_pc);
    chk($sformatf("pc4@%0d", edge_n), Instr_PC_Plus4_OUT, e_pc4);
    chk($sformatf("bubbles@%0d", edge_n), Bubble_Count, m_bc);
    chk($sformatf("misaligned@%0d", edge_n), {31'd0, Fetch_Misaligned}, {31'd0, m_mis});
    if (req_b && !v) begin
      chk($sformatf("req_hold@%0d", edge_n), {31'd0, IMem_Req}, 32'd1);
      chk($sformatf("addr_hold@%0d", edge_n), IMem_Addr, addr_b);
    end
    IMem_Valid = 1'b0;
    m_live = 1'b0;
    if (!mem_busy && IMem_Req) begin
      mem_busy = 1'b1;
      mem_addr = IMem_Addr;
      mem_issue = edge_n;
      mem_left = (lat_mode != 0) ? lat_mode : int'($urandom_range(1, 3));
    end
    if (mem_busy) begin
      mem_left--;
      if (mem_left == 0) begin
        mem_busy = 1'b0;
        IMem_Valid = 1'b1;
        m_live = 1'b1;
        IMem_Data = mem_word(mem_addr);
        resp_issue = mem_issue;
      end
    end
  endtask

  initial begin
    tbl[0]  = '{1'b0, 1'b1, 32'h00400000, 1'b1, 32'h0,        32'h0,        1'b1, 32'd1, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h00400000, 32'h00400004, 1'b1, 32'd1, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h00400004, 32'h00400008, 1'b1, 32'd1, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h00400008, 32'h0040000C, 1'b1, 32'd1, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 32'h00400100, 1'b0, 32'h0040000C, 32'h00400010, 1'b1, 32'd1, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h00400100, 32'h00400104, 1'b1, 32'd1, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 32'h0,        1'b0, 32'h00400100, 32'h00400104, 1'b0, 32'd1, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 32'h0,        1'b0, 32'h00400100, 32'h00400104, 1'b0, 32'd1, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 32'h0,        1'b0, 32'h00400100, 32'h00400104, 1'b0, 32'd1, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 32'h0,        1'b0, 32'h00400100, 32'h00400104, 1'b0, 32'd1, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h00400104, 32'h00400108, 1'b0, 32'd1, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h00400104, 32'h00400108, 1'b1, 32'd2, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h00400108, 32'h0040010C, 1'b1, 32'd2, 1'b0};
    tbl[13] = '{1'b0, 1'b1, 32'h00400202, 1'b0, 32'h0040010C, 32'h00400110, 1'b1, 32'd2, 1'b1};
    tbl[14] = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h00400200, 32'h00400204, 1'b1, 32'd2, 1'b1};

    // Reset values and 1-cycle memory streaming from RESET_PC
    lat_mode = 1;
    do_reset();
    chk("reset_req", {31'd0, IMem_Req}, 32'd0);
    chk("reset_addr", IMem_Addr, 32'd0);
    chk("reset_instr", Instr1_OUT, NOP);
    chk("reset_bc", Bubble_Count, 32'd0);
    step();
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("stream_pc%0d", i), Instr_PC_OUT, RESET_PC + 32'(4 * i));
    end
    chk("stream_bc", Bubble_Count, 32'd1);

    // 3-cycle memory: two bubbles per instruction, then a redirect squashes an in-flight fetch
    lat_mode = 3;
    do_reset();
    step();
    for (int i = 0; i < 3; i++) begin
      step(); step(); step();
      chk($sformatf("lat3_pc%0d", i), Instr_PC_OUT, RESET_PC + 32'(4 * i));
      chk($sformatf("lat3_bc%0d", i), Bubble_Count, 32'(3 + 2 * i));
    end
    Request_Alt_PC = 1'b1;
    Alt_PC = 32'h00400102;
    step();
    Request_Alt_PC = 1'b0;
    for (int i = 0; i < 6; i++) step();
    chk("squash_pc", Instr_PC_OUT, 32'h00400100);
    chk("squash_bc", Bubble_Count, 32'd13);
    chk("squash_mis", {31'd0, Fetch_Misaligned}, 32'd1);

    // PC+4 wraps at the top of the address space
    lat_mode = 1;
    do_reset();
    Request_Alt_PC = 1'b1;
    Alt_PC = 32'hFFFFFFF8;
    step();
    Request_Alt_PC = 1'b0;
    step(); step();
    chk("wrap_pc4_top", Instr_PC_Plus4_OUT, 32'd0);
    step();
    chk("wrap_pc0", Instr_PC_OUT, 32'd0);
    chk("wrap_pc4", Instr_PC_Plus4_OUT, 32'd4);

    // Asynchronous reset while a request is outstanding; the stale response must be ignored
    lat_mode = 3;
    do_reset();
    step(); step();
    chk("rst_pre_req", {31'd0, IMem_Req}, 32'd1);
    #2 RESET = 1'b0;
    #1;
    chk("arst_req", {31'd0, IMem_Req}, 32'd0);
    chk("arst_addr", IMem_Addr, 32'd0);
    chk("arst_instr", Instr1_OUT, NOP);
    chk("arst_pc", Instr_PC_OUT, 32'd0);
    chk("arst_pc4", Instr_PC_Plus4_OUT, 32'd0);
    chk("arst_bc", Bubble_Count, 32'd0);
    chk("arst_mis", {31'd0, Fetch_Misaligned}, 32'd0);
    #1 RESET = 1'b1;
    model_reset();
    IMem_Valid = 1'b1;
    IMem_Data = 32'hDEADBEEF;
    step();
    chk("rst_issue_addr", IMem_Addr, RESET_PC);
    chk("rst_issue_req", {31'd0, IMem_Req}, 32'd1);
    step(); step(); step();
    chk("rst_first_pc", Instr_PC_OUT, RESET_PC);

    // Directed table: branch delay slot, freeze with buffered word, misaligned redirect
    lat_mode = 1;
    do_reset();
    for (int i = 0; i < 15; i++) begin
      WANT_FREEZE = tbl[i].fz;
      Request_Alt_PC = tbl[i].r;
      Alt_PC = tbl[i].alt;
      step();
      chk($sformatf("tbl%0d_instr", i), Instr1_OUT, tbl[i].nop ? NOP : mem_word(tbl[i].pc));
      chk($sformatf("tbl%0d_pc", i), Instr_PC_OUT, tbl[i].pc);
      chk($sformatf("tbl%0d_pc4", i), Instr_PC_Plus4_OUT, tbl[i].pc4);
      chk($sformatf("tbl%0d_req", i), {31'd0, IMem_Req}, {31'd0, tbl[i].req});
      chk($sformatf("tbl%0d_bc", i), Bubble_Count, tbl[i].bc);
      chk($sformatf("tbl%0d_mis", i), {31'd0, Fetch_Misaligned}, {31'd0, tbl[i].mis});
    end
    WANT_FREEZE = 1'b0;
    Request_Alt_PC = 1'b0;

    // Random freeze/redirect traffic against random 1..3 cycle memory latency
    lat_mode = 0;
    do_reset();
    for (int i = 0; i < 800; i++) begin
      WANT_FREEZE = ($urandom_range(0, 3) == 0);
      Request_Alt_PC = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 7) == 0) Alt_PC = 32'hFFFFFFF0 + 32'($urandom_range(0, 15));
      else Alt_PC = 32'h00400000 + 32'($urandom_range(0, 1023));
      step();
    end
    WANT_FREEZE = 1'b0;
    Request_Alt_PC = 1'b0;
    for (int i = 0; i < 10; i++) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
